// File: rtl/nios_sqrt_pkg.sv
// Shared definitions for the square-root coprocessor: register map, CSR bit
// positions and FSM state encoding.
package nios_sqrt_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_CSR  = 2'd1;
  localparam logic [1:0] ADDR_ROOT = 2'd2;
  localparam logic [1:0] ADDR_REM  = 2'd3;

  localparam int CSR_BUSY    = 0;
  localparam int CSR_DONE    = 1;
  localparam int CSR_OVERRUN = 2;
  localparam int CSR_IRQ_EN  = 8;

  // CSR write-side bit positions
  localparam int CSR_WR_IRQ_EN  = 0;
  localparam int CSR_WR_DONE    = 1;
  localparam int CSR_WR_OVERRUN = 2;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/nios_system_sqrt_coproc_if.sv
// Avalon-MM slave bundle for the square-root coprocessor, plus its level
// interrupt line.
interface nios_system_sqrt_coproc_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write;
  logic [31:0] writedata;
  logic        read;
  logic [31:0] readdata;
  logic        irq;

  modport master (
    output address, chipselect, write, writedata, read,
    input  readdata, irq
  );

  modport slave (
    input  address, chipselect, write, writedata, read,
    output readdata, irq
  );
endinterface

// File: rtl/sqrt_step.sv
// One restoring digit-by-digit square-root iteration: consumes the next two
// operand bits and produces one root bit.
module sqrt_step #(
  parameter int ROOT_W = 16
) (
  input  logic [ROOT_W:0]   rem,
  input  logic [ROOT_W-1:0] root,
  input  logic [1:0]        top2,
  output logic [ROOT_W:0]   rem_next,
  output logic [ROOT_W-1:0] root_next
);

  logic [ROOT_W+2:0] t;
  logic [ROOT_W+2:0] sub;
  logic [ROOT_W+2:0] d;
  logic              fits;
  logic              unused_d_hi;

  // Held one bit wider than strictly needed so the borrow is an unsigned
  // compare; the remainder always fits back into ROOT_W+1 bits.
  assign t    = {rem, top2};
  assign sub  = {1'b0, root, 2'b01};
  assign fits = (t >= sub);
  assign d    = t - sub;

  assign rem_next  = fits ? d[ROOT_W:0] : t[ROOT_W:0];
  assign root_next = {root[ROOT_W-2:0], fits};

  assign unused_d_hi = ^d[ROOT_W+2:ROOT_W+1];

endmodule

// File: rtl/nios_system_sqrt_coproc.sv
// Integer square-root coprocessor on the Nios II Avalon-MM slave fabric.
// state | meaning
// IDLE  | waiting for a DATA write; results and flags hold
// RUN   | one root bit resolved per clock, counter counts down to 0
module nios_system_sqrt_coproc
  import nios_sqrt_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                      clock,
  input  logic                      reset_n,
  nios_system_sqrt_coproc_if.slave  avs
);

  localparam int ROOT_W = WIDTH / 2;
  localparam int CNT_W  = $clog2(ROOT_W + 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   operand_q, op_q;
  logic [ROOT_W-1:0]  root_acc, root_q, root_step;
  logic [ROOT_W:0]    rem_acc, rem_q, rem_step;
  logic [CNT_W-1:0]   cnt_q;
  logic               done_q, overrun_q, irq_en_q;
  logic               wr_en, data_wr, csr_wr, start, finish, busy;
  logic               unused_read;

  assign wr_en   = avs.chipselect & avs.write;
  assign data_wr = wr_en && (avs.address == ADDR_DATA);
  assign csr_wr  = wr_en && (avs.address == ADDR_CSR);
  assign busy    = (state_q == RUN);

  sqrt_step #(.ROOT_W(ROOT_W)) u_step (
    .rem       (rem_acc),
    .root      (root_acc),
    .top2      (op_q[WIDTH-1 -: 2]),
    .rem_next  (rem_step),
    .root_next (root_step)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: if (data_wr) begin
        start   = 1'b1;
        state_d = RUN;
      end
      RUN: if (cnt_q == CNT_W'(1)) begin
        finish  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      operand_q <= '0;
      op_q      <= '0;
      root_acc  <= '0;
      rem_acc   <= '0;
      root_q    <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      done_q    <= 1'b0;
      overrun_q <= 1'b0;
      irq_en_q  <= 1'b0;
    end else begin
      if (start) begin
        operand_q <= avs.writedata[WIDTH-1:0];
        op_q      <= avs.writedata[WIDTH-1:0];
        root_acc  <= '0;
        rem_acc   <= '0;
        cnt_q     <= CNT_W'(ROOT_W);
      end else if (busy) begin
        op_q     <= op_q << 2;
        root_acc <= root_step;
        rem_acc  <= rem_step;
        cnt_q    <= cnt_q - CNT_W'(1);
      end

      // Visible results only change when a run completes
      if (finish) begin
        root_q <= root_step;
        rem_q  <= rem_step;
      end

      if (finish)                                    done_q <= 1'b1;
      else if (start)                                done_q <= 1'b0;
      else if (csr_wr && avs.writedata[CSR_WR_DONE]) done_q <= 1'b0;

      if (data_wr && busy)                              overrun_q <= 1'b1;
      else if (csr_wr && avs.writedata[CSR_WR_OVERRUN]) overrun_q <= 1'b0;

      if (csr_wr) irq_en_q <= avs.writedata[CSR_WR_IRQ_EN];
    end
  end

  always_comb begin
    avs.readdata = '0;
    case (avs.address)
      ADDR_DATA: avs.readdata = 32'(operand_q);
      ADDR_CSR: begin
        avs.readdata[CSR_BUSY]    = busy;
        avs.readdata[CSR_DONE]    = done_q;
        avs.readdata[CSR_OVERRUN] = overrun_q;
        avs.readdata[CSR_IRQ_EN]  = irq_en_q;
      end
      ADDR_ROOT: avs.readdata = 32'(root_q);
      ADDR_REM:  avs.readdata = 32'(rem_q);
      default:   avs.readdata = '0;
    endcase
  end

  assign avs.irq = done_q & irq_en_q;

  // Reads are side-effect free and readdata is address-driven only
  assign unused_read = avs.read;

endmodule

// File: tb/tb_nios_system_sqrt_coproc.sv
// Directed and property-checked bench for the square-root coprocessor.
module tb_nios_system_sqrt_coproc;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  int   errors  = 0;
  int   checks  = 0;

  nios_system_sqrt_coproc_if bus ();

  nios_system_sqrt_coproc dut (
    .clock   (clock),
    .reset_n (reset_n),
    .avs     (bus)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] addr, input logic [31:0] data);
    @(negedge clock);
    bus.address    = addr;
    bus.writedata  = data;
    bus.chipselect = 1'b1;
    bus.write      = 1'b1;
    @(posedge clock);
    #1;
    bus.chipselect = 1'b0;
    bus.write      = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
    bus.address    = addr;
    bus.chipselect = 1'b1;
    bus.read       = 1'b1;
    #1;
    data           = bus.readdata;
    bus.chipselect = 1'b0;
    bus.read       = 1'b0;
  endtask

  // Returns the number of clock edges until done is seen, 0 on timeout
  task automatic wait_done(output int lat);
    logic [31:0] s;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock);
      #1;
      bus_read(2'd1, s);
      if (s[1]) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run(input logic [31:0] x, output logic [31:0] r,
                     output logic [31:0] m, output int lat);
    bus_write(2'd0, x);
    wait_done(lat);
    bus_read(2'd2, r);
    bus_read(2'd3, m);
  endtask

  initial begin
    logic [31:0] v, r, m;
    int lat;
    longint unsigned x64, r64;

    bus.address = '0; bus.chipselect = 1'b0; bus.write = 1'b0;
    bus.writedata = '0; bus.read = 1'b0;

    repeat (2) @(posedge clock);
    #1;
    bus_read(2'd0, v); check("rst_data", v, 32'h0);
    bus_read(2'd1, v); check("rst_csr", v, 32'h0);
    bus_read(2'd2, v); check("rst_root", v, 32'h0);
    bus_read(2'd3, v); check("rst_rem", v, 32'h0);
    check("rst_irq", 32'(bus.irq), 32'h0);
    @(negedge clock);
    reset_n = 1'b1;

    bus_write(2'd0, 32'd144);
    bus_read(2'd1, v); check("busy_144", v, 32'h1);
    wait_done(lat);    check("lat_144", lat, 16);
    bus_read(2'd2, v); check("root_144", v, 32'd12);
    bus_read(2'd3, v); check("rem_144", v, 32'd0);
    bus_read(2'd1, v); check("csr_144", v, 32'h2);
    bus_read(2'd0, v); check("data_144", v, 32'd144);

    bus_write(2'd0, 32'd200);
    repeat (8) @(posedge clock);
    #1;
    bus_read(2'd2, v); check("root_hold_mid", v, 32'd12);
    bus_read(2'd1, v); check("csr_mid_200", v, 32'h1);
    wait_done(lat);    check("lat_200_rest", lat, 8);
    bus_read(2'd2, v); check("root_200", v, 32'd14);
    bus_read(2'd3, v); check("rem_200", v, 32'd4);

    run(32'd0, r, m, lat);
    check("lat_0", lat, 16); check("root_0", r, 32'd0); check("rem_0", m, 32'd0);

    run(32'hFFFF_FFFF, r, m, lat);
    check("lat_max", lat, 16); check("root_max", r, 32'h0000_FFFF); check("rem_max", m, 32'h0001_FFFE);

    bus_write(2'd2, 32'h0000_DEAD);
    bus_write(2'd3, 32'h0000_BEEF);
    bus_read(2'd2, v); check("root_wr_ignored", v, 32'h0000_FFFF);
    bus_read(2'd3, v); check("rem_wr_ignored", v, 32'h0001_FFFE);

    bus_write(2'd0, 32'd144);
    repeat (4) @(posedge clock);
    bus_write(2'd0, 32'd81);
    bus_read(2'd1, v); check("csr_overrun_busy", v, 32'h5);
    wait_done(lat);    check("lat_overrun", lat, 11);
    bus_read(2'd2, v); check("root_overrun", v, 32'd12);
    bus_read(2'd1, v); check("csr_overrun_done", v, 32'h6);
    bus_read(2'd0, v); check("data_overrun", v, 32'd144);
    bus_write(2'd1, 32'h4);
    bus_read(2'd1, v); check("csr_w1c_overrun", v, 32'h2);
    run(32'd81, r, m, lat);
    check("root_81", r, 32'd9); check("rem_81", m, 32'd0);

    bus_write(2'd0, 32'd200);
    repeat (15) @(posedge clock);
    bus_write(2'd1, 32'h2);
    bus_read(2'd1, v); check("done_wins_w1c", v, 32'h2);
    bus_read(2'd2, v); check("root_200b", v, 32'd14);

    bus_write(2'd1, 32'h3);
    bus_read(2'd1, v); check("csr_irq_en", v, 32'h100);
    check("irq_idle", 32'(bus.irq), 32'h0);
    bus_write(2'd0, 32'd49);
    check("irq_busy", 32'(bus.irq), 32'h0);
    wait_done(lat);    check("lat_49", lat, 16);
    check("irq_done", 32'(bus.irq), 32'h1);
    bus_read(2'd2, v); check("root_49", v, 32'd7);
    bus_read(2'd1, v); check("csr_49", v, 32'h102);
    bus_write(2'd1, 32'h3);
    check("irq_w1c_done", 32'(bus.irq), 32'h0);
    run(32'd49, r, m, lat);
    check("irq_done2", 32'(bus.irq), 32'h1);
    bus_write(2'd1, 32'h0);
    check("irq_en_off", 32'(bus.irq), 32'h0);
    bus_read(2'd1, v); check("csr_en_off", v, 32'h2);

    bus_write(2'd1, 32'h3);
    bus_write(2'd0, 32'd144);
    repeat (7) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    bus_read(2'd1, v); check("arst_csr", v, 32'h0);
    bus_read(2'd2, v); check("arst_root", v, 32'h0);
    bus_read(2'd3, v); check("arst_rem", v, 32'h0);
    bus_read(2'd0, v); check("arst_data", v, 32'h0);
    check("arst_irq", 32'(bus.irq), 32'h0);
    @(negedge clock);
    reset_n = 1'b1;
    run(32'd200, r, m, lat);
    check("lat_after_rst", lat, 16); check("root_after_rst", r, 32'd14); check("rem_after_rst", m, 32'd4);
    bus_read(2'd1, v); check("csr_after_rst", v, 32'h2);

    for (int i = 0; i < 2000; i++) begin
      logic [31:0] x;
      x = $urandom;
      if (i % 4 == 1) x = x >> $urandom_range(31, 8);
      run(x, r, m, lat);
      x64 = 64'(x);
      r64 = 64'(r);
      check("sweep_lat", lat, 16);
      check("sweep_root_lo", 32'(r64 * r64 <= x64), 32'h1);
      check("sweep_root_hi", 32'((r64 + 1) * (r64 + 1) > x64), 32'h1);
      check("sweep_rem", m, 32'(x64 - r64 * r64));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
